sumador_serial_nbits: RTL and testbench

Bit-serial N-bit adder. It is the additive counterpart of the ALU's combinational N-bit subtractor and produces the same four status flags: zero, negativo, cOut, overflow. It processes one bit per clock, LSB first, under a start/done handshake. It serves area-constrained ALU configurations and the multi-cycle datapath, where Q and the flags feed the status register.

---
 rtl/sumador_serial_nbits.sv | 105 ++++++++++
 tb/tb_sumador_serial_nbits.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial_nbits.sv
// Bit-serial N-bit adder, LSB first, start/done handshake.
// Result and status flags are loaded together when the last bit is done.
module sumador_serial_nbits #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic         zero,
  output logic         negativo,
  output logic         cOut,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SUMA,
    FIN
  } state_t;

  state_t state, state_n;

  logic [N-1:0]  sa, sb;
  logic [N-2:0]  sr;
  logic          c;
  logic [CW-1:0] cnt;

  logic          s, cn, last;
  logic [N-1:0]  sum;

  assign s    = sa[0] ^ sb[0] ^ c;
  assign cn   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign last = (cnt == CW'(N - 1));
  // sr holds the bits already produced; s is the bit of this step
  assign sum  = {s, sr};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = SUMA;
      SUMA: if (last) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      Q        <= '0;
      zero     <= 1'b0;
      negativo <= 1'b0;
      cOut     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa   <= A;
            sb   <= B;
            c    <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        SUMA: begin
          sr  <= sum[N-1:1];
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= cn;
          cnt <= cnt + 1'b1;
          if (last) begin
            // c is still the carry into bit N-1 here
            Q        <= sum;
            zero     <= (sum == '0);
            negativo <= s;
            cOut     <= cn;
            overflow <= c ^ cn;
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
        FIN: done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial_nbits.sv
// Bench for the bit-serial adder: N=3 and N=8 instances,
// table vectors plus scoreboard-checked multi-cycle sequences.
module tb_sumador_serial_nbits;

  typedef struct {
    int         n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       z;
    logic       ng;
    logic       co;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st;
  logic [7:0] a [2];
  logic [7:0] b [2];
  logic [2:0] q3;
  logic [7:0] q8;
  logic [1:0] z, ng, co, ov, bz, dn;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   acc [2];
  logic pb [2];
  vec_t sbq [$];
  vec_t vt [10];

  sumador_serial_nbits #(.N(3)) u3 (
    .clk(clk), .rst(rst), .start(st[0]),
    .A(a[0][2:0]), .B(b[0][2:0]), .Q(q3),
    .zero(z[0]), .negativo(ng[0]), .cOut(co[0]),
    .overflow(ov[0]), .busy(bz[0]), .done(dn[0])
  );

  sumador_serial_nbits #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(st[1]),
    .A(a[1]), .B(b[1]), .Q(q8),
    .zero(z[1]), .negativo(ng[1]), .cOut(co[1]),
    .overflow(ov[1]), .busy(bz[1]), .done(dn[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] qv(int i);
    return (i == 0) ? {5'b0, q3} : q8;
  endfunction

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bz[i] && dn[i]) begin
        nerr++;
        $display("FAIL busy_done dut%0d: both high, required exclusive", i);
      end
      if (bz[i] && !pb[i]) acc[i] = cyc;
      pb[i] = bz[i];
      if (dn[i]) begin
        nvec++;
        if (sbq.size() == 0) begin
          nerr++;
          $display("FAIL spurious_done dut%0d: done=1 at cycle %0d, none expected",
                   i, cyc);
        end else begin
          vec_t e;
          logic [11:0] got, want;
          e = sbq.pop_front();
          got  = {qv(i), z[i], ng[i], co[i], ov[i]};
          want = {e.q, e.z, e.ng, e.co, e.ov};
          if (got !== want || e.n != (i == 0 ? 3 : 8)) begin
            nerr++;
            $display("FAIL result dut%0d a=%h b=%h: got Q/z/n/c/v=%h required %h",
                     i, e.a, e.b, got, want);
          end
          nvec++;
          if (cyc - acc[i] != e.n) begin
            nerr++;
            $display("FAIL latency dut%0d: got %0d cycles required %0d",
                     i, cyc - acc[i], e.n);
          end
        end
      end
    end
  end

  task automatic check_zero(int i, string nm);
    logic [13:0] got;
    got = {qv(i), z[i], ng[i], co[i], ov[i], bz[i], dn[i]};
    nvec++;
    if (got !== 14'h0) begin
      nerr++;
      $display("FAIL %s dut%0d: got outputs %h required 0", nm, i, got);
    end
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL timeout: %0d results pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_bit(int i, bit isdone, output int c);
    int k;
    k = 0;
    c = -1;
    while (k < 40) begin
      @(negedge clk);
      if (isdone ? dn[i] : bz[i]) begin
        c = cyc;
        break;
      end
      k++;
    end
    if (c < 0) begin
      nerr++;
      $display("FAIL wait dut%0d %s: got timeout required event", i,
               isdone ? "done" : "busy");
    end
  endtask

  task automatic apply(vec_t v);
    int s;
    s = (v.n == 3) ? 0 : 1;
    @(posedge clk);
    #1;
    a[s] = v.a;
    b[s] = v.b;
    st[s] = 1'b1;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    st[s] = 1'b0;
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   d1, d2, t;
    vec_t e;
    vt[0] = '{3, 8'h03, 8'h02, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{3, 8'h07, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{3, 8'h04, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3] = '{3, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{3, 8'h05, 8'h06, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{8, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{8, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{8, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8] = '{8, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[9] = '{8, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    pb[0] = 1'b0;
    pb[1] = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    rst = 1'b1;
    st = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a[i] = '0;
      b[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_zero(0, "idle");
      check_zero(1, "idle");
    end

    for (int i = 0; i < 10; i++) apply(vt[i]);

    // N=3: restart and operand change mid-operation are ignored
    @(posedge clk);
    #1;
    a[0] = 8'h01;
    b[0] = 8'h01;
    st[0] = 1'b1;
    sbq.push_back(vt[3]);
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    #1;
    a[0] = 8'h07;
    b[0] = 8'h07;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    wait_empty();
    repeat (8) @(negedge clk);

    // N=8: start held high, one result every N+2 cycles
    @(posedge clk);
    #1;
    a[1] = 8'h7F;
    b[1] = 8'h01;
    st[1] = 1'b1;
    sbq.push_back(vt[6]);
    wait_bit(1, 1'b0, t);
    a[1] = 8'hFF;
    sbq.push_back(vt[7]);
    wait_bit(1, 1'b1, d1);
    wait_bit(1, 1'b0, t);
    st[1] = 1'b0;
    nvec++;
    if (q8 !== 8'h80) begin
      nerr++;
      $display("FAIL hold_q: got %h required 80 during SUMA", q8);
    end
    wait_bit(1, 1'b1, d2);
    nvec++;
    if (d2 - d1 != 10) begin
      nerr++;
      $display("FAIL spacing: got %0d cycles required 10", d2 - d1);
    end
    wait_empty();

    // N=8: reset on the 4th SUMA cycle aborts the operation
    @(posedge clk);
    #1;
    a[1] = 8'h55;
    b[1] = 8'hAA;
    st[1] = 1'b1;
    e = vt[5];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero(1, "abort");
    check_zero(0, "abort");
    repeat (12) @(negedge clk);
    apply(vt[5]);

    repeat (4) @(negedge clk);
    nvec++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL pending: got %0d results left required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
